// File: rtl/toggle_pulse_rx.sv
// toggle_pulse_rx
//   Receive side of a toggle-signalling link. A T flip-flop sender flips tog_in once per event;
//   this block synchronises the line into clk, detects each flip (rising or falling) and emits a
//   one-cycle registered pulse per event. It also counts events and flags toggles that arrive
//   within MIN_GAP cycles of the previous one (sticky overrun).
//
//   Optional feature macro: TOG_PULSE_ACK_EN -- adds ack_tog, which flips together with each pulse
//   so the sender side can confirm events with the same toggle scheme in reverse.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   tog_in     in   1        toggle line from the sender (may be asynchronous to clk)
//   enable     in   1        1 = pulses, counting and gap checking active
//   clr_ovr    in   1        clears the overrun flag (a simultaneous new overrun wins)
//   pulse_out  out  1        one-cycle pulse per detected toggle
//   event_cnt  out  COUNT_W  detected events, wraps
//   overrun    out  1        sticky: toggle seen inside the MIN_GAP window
//   ack_tog    out  1        (TOG_PULSE_ACK_EN only) flips with every pulse

module toggle_pulse_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned COUNT_W     = 8,
   parameter int unsigned MIN_GAP     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tog_in,
   input  logic               enable,
   input  logic               clr_ovr,
   output logic               pulse_out,
   output logic [COUNT_W-1:0] event_cnt,
   output logic               overrun
`ifdef TOG_PULSE_ACK_EN
   ,
   output logic               ack_tog
`endif
);

   localparam int unsigned      ARM_W      = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_DONE   = ARM_W'(SYNC_STAGES + 1);
   localparam int unsigned      GAP_W      = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);

   typedef enum logic [0:0] {StIdle, StGap} state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [ARM_W-1:0]       arm_q;
   logic                   pulse_q;
   logic [COUNT_W-1:0]     cnt_q;
   logic                   ovr_q;
   state_e                 state_q, state_d;
   logic [GAP_W-1:0]       gap_q, gap_d;

   logic sync_out;
   logic armed;
   logic edge_det;
   logic fire;
   logic ovr_set;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign armed    = (arm_q == ARM_DONE);
   assign edge_det = sync_out ^ prev_q;
   // While disarmed, prev_q still follows the synchroniser so the level present at reset
   // release is adopted silently.
   assign fire     = edge_det & enable & armed;

   // Gap window FSM; frozen entirely while enable is low.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      ovr_set = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fire && (MIN_GAP != 0)) begin
               state_d = StGap;
               gap_d   = GAP_RELOAD;
            end
         end
         StGap: begin
            if (enable) begin
               if (fire) begin
                  ovr_set = 1'b1;
                  gap_d   = GAP_RELOAD;
               end else if (gap_q == '0) begin
                  state_d = StIdle;
               end else begin
                  gap_d = gap_q - GAP_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         arm_q   <= '0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
         state_q <= StIdle;
         gap_q   <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], tog_in};
         prev_q  <= sync_out;
         if (!armed) begin
            arm_q <= arm_q + ARM_W'(1);
         end
         pulse_q <= fire;
         if (fire) begin
            cnt_q <= cnt_q + COUNT_W'(1);
         end
         // Set has priority over clear.
         ovr_q   <= ovr_set | (ovr_q & ~clr_ovr);
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   assign pulse_out = pulse_q;
   assign event_cnt = cnt_q;
   assign overrun   = ovr_q;

`ifdef TOG_PULSE_ACK_EN
   logic ack_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q <= 1'b0;
      end else if (fire) begin
         ack_q <= ~ack_q;
      end
   end

   assign ack_tog = ack_q;
`endif

endmodule
